// File: rtl/wb_buffer.sv
// Writeback buffer: a small in-order FIFO between execute and the register-file write port,
// with youngest-match forwarding to decode and a retired-result counter.
module wb_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_waddr_i,
    input  logic [31:0] rd_wdata_i,
    input  logic        flush_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    input  logic        rf_ready_i,
    input  logic [4:0]  fwd_raddr_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic [31:0] retire_cnt_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StPart  = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            entry_we_q   [DEPTH];
    logic [4:0]      entry_addr_q [DEPTH];
    logic [31:0]     entry_data_q [DEPTH];
    logic [31:0]     retire_cnt_q;

    logic [1:0]      state;
    logic            we_eff;
    logic            head_we;
    logic            push;
    logic            pop;
    logic [PtrW:0]   fwd_sum;
    logic [PtrW-1:0] fwd_idx;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        if (count_q == '0) begin
            state = StEmpty;
        end else if (count_q == CntW'(DEPTH)) begin
            state = StFull;
        end else begin
            state = StPart;
        end
    end

    assign we_eff     = rd_we_i & (rd_waddr_i != 5'd0);
    assign head_we    = entry_we_q[rd_ptr_q];
    // Readiness depends only on occupancy and flush, never on rf_ready_i.
    assign ex_ready_o = (state != StFull) & ~flush_i;
    assign push       = ex_valid_i & ex_ready_o;
    assign pop        = (state != StEmpty) & ~flush_i & (rf_ready_i | ~head_we);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_we_q[i]   <= 1'b0;
                entry_addr_q[i] <= '0;
                entry_data_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                entry_we_q[wr_ptr_q]   <= we_eff;
                entry_addr_q[wr_ptr_q] <= rd_waddr_i;
                entry_data_q[wr_ptr_q] <= rd_wdata_i;
            end
            if (pop) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (state != StEmpty) begin
            rf_we_o    = head_we & ~flush_i;
            rf_waddr_o = entry_addr_q[rd_ptr_q];
            rf_wdata_o = entry_data_q[rd_ptr_q];
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_sum    = '0;
        fwd_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_sum = {1'b0, rd_ptr_q} + (PtrW + 1)'(k);
            if (fwd_sum >= (PtrW + 1)'(DEPTH)) begin
                fwd_sum = fwd_sum - (PtrW + 1)'(DEPTH);
            end
            fwd_idx = fwd_sum[PtrW-1:0];
            if ((CntW'(k) < count_q) && entry_we_q[fwd_idx] && (fwd_raddr_i != 5'd0) &&
                (entry_addr_q[fwd_idx] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entry_data_q[fwd_idx];
            end
        end
    end

    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a queue-based model of the buffer.
module tb_wb_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        rd_we_i;
    logic [4:0]  rd_waddr_i;
    logic [31:0] rd_wdata_i;
    logic        flush_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_ready_i;
    logic [4:0]  fwd_raddr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [31:0] retire_cnt_o;

    int          n_vec;
    int          n_fail;
    logic [37:0] mq[$];
    logic [31:0] m_retire;

    wb_buffer #(.DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .rd_we_i      (rd_we_i),
        .rd_waddr_i   (rd_waddr_i),
        .rd_wdata_i   (rd_wdata_i),
        .flush_i      (flush_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_ready_i   (rf_ready_i),
        .fwd_raddr_i  (fwd_raddr_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
        .retire_cnt_o (retire_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic fl, input logic rdy,
                         input logic [4:0] ra);
        ex_valid_i  = v;
        rd_we_i     = we;
        rd_waddr_i  = a;
        rd_wdata_i  = d;
        flush_i     = fl;
        rf_ready_i  = rdy;
        fwd_raddr_i = ra;
    endtask

    task automatic idle(input logic rdy, input logic [4:0] ra);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, rdy, ra);
    endtask

    // Expected outputs derived from the queue contents and current inputs.
    task automatic compare();
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_hit;
        logic [31:0] e_fd;
        e_ready = (mq.size() < 2) && !flush_i;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (mq.size() > 0) begin
            e_we   = mq[0][37] && !flush_i;
            e_addr = mq[0][36:32];
            e_data = mq[0][31:0];
        end
        e_hit = 1'b0;
        e_fd  = '0;
        if (fwd_raddr_i != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i][37] && mq[i][36:32] == fwd_raddr_i) begin
                    e_hit = 1'b1;
                    e_fd  = mq[i][31:0];
                end
            end
        end
        chk("ex_ready_o", {31'd0, ex_ready_o}, {31'd0, e_ready});
        chk("rf_we_o", {31'd0, rf_we_o}, {31'd0, e_we});
        chk("rf_waddr_o", {27'd0, rf_waddr_o}, {27'd0, e_addr});
        chk("rf_wdata_o", rf_wdata_o, e_data);
        chk("fwd_hit_o", {31'd0, fwd_hit_o}, {31'd0, e_hit});
        chk("fwd_data_o", fwd_data_o, e_fd);
        chk("retire_cnt_o", retire_cnt_o, m_retire);
    endtask

    task automatic settle();
        #2;
        compare();
    endtask

    task automatic tick();
        logic do_push;
        logic do_pop;
        @(posedge clk_i);
        if (!rst_ni) begin
            mq.delete();
            m_retire = '0;
        end else if (flush_i) begin
            mq.delete();
        end else begin
            do_push = ex_valid_i && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && (rf_ready_i || !mq[0][37]);
            if (do_pop) begin
                void'(mq.pop_front());
                m_retire = m_retire + 32'd1;
            end
            if (do_push) begin
                mq.push_back({rd_we_i && (rd_waddr_i != 5'd0), rd_waddr_i, rd_wdata_i});
            end
        end
        #1;
    endtask

    task automatic release_reset();
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        mq.delete();
        m_retire = '0;
        idle(1'b0, 5'd0);
        #1;
        compare();
        @(posedge clk_i);
        #1;
        release_reset();
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        m_retire = '0;
        rst_ni   = 1'b0;
        idle(1'b0, 5'd5);
        #3;
        compare();
        chk("rst ex_ready", {31'd0, ex_ready_o}, 32'd1);
        chk("rst rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst rf_waddr", {27'd0, rf_waddr_o}, 32'd0);
        chk("rst rf_wdata", rf_wdata_o, 32'd0);
        chk("rst fwd_hit", {31'd0, fwd_hit_o}, 32'd0);
        chk("rst fwd_data", fwd_data_o, 32'd0);
        chk("rst retire", retire_cnt_o, 32'd0);
        #5;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single write.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 5'd0); settle(); tick();
        idle(1'b1, 5'd0); settle();
        chk("single rf_we", {31'd0, rf_we_o}, 32'd1);
        chk("single rf_waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("single rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        tick();
        idle(1'b1, 5'd0); settle();
        chk("single rf_we after", {31'd0, rf_we_o}, 32'd0);
        chk("single retire", retire_cnt_o, 32'd1);
        tick();

        // Backpressure.
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 5'd0); settle(); tick();
        drive(1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 5'd0); settle(); tick();
        idle(1'b0, 5'd0); settle();
        chk("bp full ready", {31'd0, ex_ready_o}, 32'd0);
        tick();
        idle(1'b1, 5'd0); settle();
        chk("bp first addr", {27'd0, rf_waddr_o}, 32'd1);
        chk("bp first data", rf_wdata_o, 32'h11);
        chk("bp first we", {31'd0, rf_we_o}, 32'd1);
        tick();
        idle(1'b1, 5'd0); settle();
        chk("bp second addr", {27'd0, rf_waddr_o}, 32'd2);
        chk("bp second data", rf_wdata_o, 32'h22);
        chk("bp ready back", {31'd0, ex_ready_o}, 32'd1);
        tick();
        idle(1'b1, 5'd0); settle();
        chk("bp drained we", {31'd0, rf_we_o}, 32'd0);
        chk("bp retire", retire_cnt_o, 32'd2);
        tick();

        // x0 and non-writing results drain without writes.
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0); settle(); tick();
        drive(1'b1, 1'b0, 5'd7, 32'h66, 1'b0, 1'b0, 5'd0); settle();
        chk("nowr x0 we", {31'd0, rf_we_o}, 32'd0);
        tick();
        idle(1'b0, 5'd0); settle();
        chk("nowr x7 we", {31'd0, rf_we_o}, 32'd0);
        chk("nowr x7 addr", {27'd0, rf_waddr_o}, 32'd7);
        tick();
        idle(1'b0, 5'd0); settle();
        chk("nowr retire", retire_cnt_o, 32'd2);
        chk("nowr empty addr", {27'd0, rf_waddr_o}, 32'd0);
        tick();

        // Forwarding picks the youngest match.
        do_reset();
        drive(1'b1, 1'b1, 5'd3, 32'hA, 1'b0, 1'b0, 5'd3); settle(); tick();
        drive(1'b1, 1'b1, 5'd3, 32'hB, 1'b0, 1'b0, 5'd3); settle();
        chk("fwd one hit", {31'd0, fwd_hit_o}, 32'd1);
        chk("fwd one data", fwd_data_o, 32'hA);
        tick();
        idle(1'b0, 5'd3); settle();
        chk("fwd young hit", {31'd0, fwd_hit_o}, 32'd1);
        chk("fwd young data", fwd_data_o, 32'hB);
        tick();
        idle(1'b0, 5'd0); settle();
        chk("fwd x0 hit", {31'd0, fwd_hit_o}, 32'd0);
        chk("fwd x0 data", fwd_data_o, 32'd0);
        tick();

        // Flush while full.
        do_reset();
        drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd0); settle(); tick();
        drive(1'b1, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b0, 5'd0); settle(); tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9); settle();
        chk("flush rf_we", {31'd0, rf_we_o}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 5'd9); settle();
            chk("flush after we", {31'd0, rf_we_o}, 32'd0);
            chk("flush after ready", {31'd0, ex_ready_o}, 32'd1);
            tick();
        end
        chk("flush retire", retire_cnt_o, 32'd0);

        // Asynchronous reset with one entry held.
        do_reset();
        drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 5'd0); settle(); tick();
        drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd0); settle(); tick();
        idle(1'b0, 5'd4); settle();
        chk("arst pre hit", {31'd0, fwd_hit_o}, 32'd1);
        chk("arst pre retire", retire_cnt_o, 32'd1);
        #1;
        rst_ni = 1'b0;
        mq.delete();
        m_retire = '0;
        #1;
        compare();
        chk("arst rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("arst rf_wdata", rf_wdata_o, 32'd0);
        chk("arst fwd_hit", {31'd0, fwd_hit_o}, 32'd0);
        chk("arst retire", retire_cnt_o, 32'd0);
        @(posedge clk_i);
        #1;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 5'd4); settle();
            chk("arst after we", {31'd0, rf_we_o}, 32'd0);
            tick();
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)));
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Parameters
REQ-001 The block SHALL have DEPTH, default 2, giving the number of writeback buffer entries; only DEPTH=2 is required to be supported.

Interface
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ex_valid_i, input, 1 bit: the execute stage presents a completed instruction result.
REQ-005 The block SHALL have port ex_ready_o, output, 1 bit: the buffer can accept a result this cycle.
REQ-006 The block SHALL have port rd_we_i, input, 1 bit: the result writes a register.
REQ-007 The block SHALL have port rd_waddr_i, input, 5 bits: destination register.
REQ-008 The block SHALL have port rd_wdata_i, input, 32 bits: result data.
REQ-009 The block SHALL have port flush_i, input, 1 bit: kill all buffered results.
REQ-010 The block SHALL have port rf_we_o, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port rf_waddr_o, output, 5 bits: register-file write address.
REQ-012 The block SHALL have port rf_wdata_o, output, 32 bits: register-file write data.
REQ-013 The block SHALL have port rf_ready_i, input, 1 bit: the register-file write port accepts the write this cycle.
REQ-014 The block SHALL have port fwd_raddr_i, input, 5 bits: forwarding lookup address from decode.
REQ-015 The block SHALL have port fwd_hit_o, output, 1 bit: a buffered pending write matches fwd_raddr_i.
REQ-016 The block SHALL have port fwd_data_o, output, 32 bits: data of the matching entry.
REQ-017 The block SHALL have port retire_cnt_o, output, 32 bits: count of retired results.

Function
REQ-018 The block SHALL implement a DEPTH-entry in-order FIFO; each entry holds {we_eff, waddr, wdata}, where we_eff = rd_we_i & (rd_waddr_i != 0).
REQ-019 ex_ready_o SHALL equal (count < DEPTH) & ~flush_i, and SHALL have no combinational path from rf_ready_i.
REQ-020 A push SHALL occur when ex_valid_i & ex_ready_o; the entry SHALL become visible at the head/forward outputs in the next cycle (1-cycle latency).
REQ-021 When count > 0, the head entry SHALL drive rf_we_o = head.we_eff & ~flush_i, together with rf_waddr_o and rf_wdata_o.
REQ-022 When count == 0, rf_we_o, rf_waddr_o and rf_wdata_o SHALL all be 0.
REQ-023 A pop SHALL occur when count > 0 & ~flush_i & (rf_ready_i | ~head.we_eff); non-writing entries therefore drain one per cycle unconditionally.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-025 On flush_i, the next-cycle count SHALL be 0 and the pointers SHALL reset; no push, pop or retire_cnt_o increment occurs in the flush cycle; flush_i has priority over all other events.
REQ-026 fwd_hit_o SHALL be 1 when fwd_raddr_i != 0 and some valid entry has we_eff and a waddr equal to fwd_raddr_i; it is combinational.
REQ-027 When more than one entry matches, fwd_data_o SHALL take the youngest entry's data; with no match, fwd_data_o SHALL be 0.
REQ-028 retire_cnt_o SHALL increment by 1 on each pop and SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 The state machine SHALL be derived from count: EMPTY (0), PART (1), FULL (2).
- EMPTY goes to PART on a push.
- PART goes to FULL on push without pop, and to EMPTY on pop without push.
- FULL goes to PART on pop.
- Any state goes to EMPTY on flush.

Reset
REQ-030 On rst_ni low, the block SHALL asynchronously clear count, pointers, all entries and retire_cnt_o.
REQ-031 During reset, outputs SHALL be: ex_ready_o=1 once flush_i=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_hit_o=0, fwd_data_o=0, retire_cnt_o=0.
REQ-032 Reset asserted mid-operation SHALL discard buffered entries with no register-file write issued afterwards.

Verification
REQ-033 The bench SHALL cover the single write: push {we=1,x5,0xDEADBEEF} with rf_ready_i=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; the cycle after, rf_we_o=0 and retire_cnt_o=1.
REQ-034 The bench SHALL cover backpressure: rf_ready_i=0, then push x1=0x11 and x2=0x22 -> ex_ready_o=0 while full; raise rf_ready_i -> writes x1 then x2 in order, and ex_ready_o returns to 1.
REQ-035 The bench SHALL cover x0/no-write: push {we=1,x0,0x55} and {we=0,x7,0x66} with rf_ready_i=0 -> rf_we_o stays 0, both drain in 2 cycles, retire_cnt_o=2.
REQ-036 The bench SHALL cover forwarding: buffer x3=0xA then x3=0xB (rf_ready_i=0) with fwd_raddr_i=3 -> fwd_hit_o=1, fwd_data_o=0xB; fwd_raddr_i=0 -> fwd_hit_o=0.
REQ-037 The bench SHALL cover flush while full: with 2 entries buffered, assert flush_i for 1 cycle -> rf_we_o=0 in that cycle, count becomes 0, and no write of either entry ever occurs.
REQ-038 The bench SHALL cover async reset mid-stream: drop rst_ni between clock edges with 1 entry held -> outputs clear immediately, with retire_cnt_o=0.
